// File: rtl/extbus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : extbus_sequencer
// Brief    : Sequences one memory read/write or busio register access per
//            four-phase req/done handshake, with a bounded memory-ready wait.
// Revision : 1.0 - initial release
// ============================================================================
module extbus_sequencer #(
  parameter int WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic [1:0] i_op,
  input  logic [1:0] i_reg,
  input  logic       i_mem_ready,
  output logic [1:0] o_arx,
  output logic       o_ecx,
  output logic       o_wrx,
  output logic       o_astb,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_done,
  output logic       o_error
);

  localparam int              c_CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_REG  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_op_wr;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_arx;
  logic            r_ecx;
  logic            r_wrx;
  logic            r_astb;
  logic            r_rd;
  logic            r_wr;
  logic            r_done;
  logic            r_error;

  // Outputs are loaded together with the state they belong to, so each
  // strobe is a plain flop output with no decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_DONE;
      r_op_wr <= 1'b0;
      r_cnt   <= '0;
      r_arx   <= 2'b11;
      r_ecx   <= 1'b0;
      r_wrx   <= 1'b0;
      r_astb  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b1;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_DONE: begin
          if (!i_req) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_req) begin
            r_op_wr <= i_op[0];
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_ecx   <= 1'b1;
            if (!i_op[1]) begin
              r_state <= ST_ADDR;
              r_arx   <= 2'b00;
              r_astb  <= 1'b1;
            end else begin
              r_state <= ST_REG;
              r_arx   <= i_reg;
              r_wrx   <= i_op[0];
            end
          end
        end
        ST_ADDR: begin
          r_state <= ST_DATA;
          r_arx   <= 2'b01;
          r_astb  <= 1'b0;
          r_rd    <= ~r_op_wr;
          r_wr    <= r_op_wr;
        end
        ST_DATA: begin
          // Ready is tested before the timeout, so ready in the last allowed
          // cycle still completes without error.
          if (i_mem_ready || (r_cnt == c_LAST)) begin
            r_state <= ST_DONE;
            r_error <= ~i_mem_ready;
            r_arx   <= 2'b11;
            r_ecx   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: begin
          r_state <= ST_DONE;
          r_arx   <= 2'b11;
          r_ecx   <= 1'b0;
          r_wrx   <= 1'b0;
          r_astb  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  // Read data is latched into the busio register the same cycle memory
  // presents it, hence the one combinational path from i_mem_ready.
  assign o_wrx   = r_wrx | (r_rd & i_mem_ready);
  assign o_arx   = r_arx;
  assign o_ecx   = r_ecx;
  assign o_astb  = r_astb;
  assign o_rd    = r_rd;
  assign o_wr    = r_wr;
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_extbus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_extbus_sequencer
// Brief    : Randomized self-checking bench for extbus_sequencer against a
//            transaction-level cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_extbus_sequencer;

  localparam int W = 4;

  logic       clk;
  logic       reset;
  logic       i_req;
  logic [1:0] i_op;
  logic [1:0] i_reg;
  logic       i_mem_ready;
  logic [1:0] o_arx;
  logic       o_ecx;
  logic       o_wrx;
  logic       o_astb;
  logic       o_rd;
  logic       o_wr;
  logic       o_done;
  logic       o_error;

  int   n_checks;
  int   n_errors;
  logic exp_err;

  extbus_sequencer #(.WAIT_MAX(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_op        (i_op),
    .i_reg       (i_reg),
    .i_mem_ready (i_mem_ready),
    .o_arx       (o_arx),
    .o_ecx       (o_ecx),
    .o_wrx       (o_wrx),
    .o_astb      (o_astb),
    .o_rd        (o_rd),
    .o_wr        (o_wr),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {arx[1:0], ecx, wrx, astb, rd, wr, done, error}
  function automatic logic [8:0] mkv(input int arx, input int ecx, input int wrx,
                                     input int astb, input int rd, input int wr,
                                     input int dn, input int er);
    return {arx[1:0], ecx[0], wrx[0], astb[0], rd[0], wr[0], dn[0], er[0]};
  endfunction

  function automatic logic [8:0] obs();
    return {o_arx, o_ecx, o_wrx, o_astb, o_rd, o_wr, o_done, o_error};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b (arx,ecx,wrx,astb,rd,wr,done,err) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with the DUT idle. d = DATA cycles before
  // ready (d >= W means ready never comes); drop_at = busy cycle at which
  // i_req is withdrawn early (beyond the op length means never).
  task automatic run_txn(input int op, input int rg, input int d, input int drop_at);
    int         n_data;
    int         nd;
    int         h;
    bit         dropped;
    logic       rdy;
    logic [8:0] e;
    n_data  = (op < 2) ? ((d < W) ? d + 1 : W) : 0;
    nd      = (op < 2) ? 1 + n_data : 1;
    dropped = 0;
    i_req = 1'b1;
    i_op  = op[1:0];
    i_reg = rg[1:0];
    i_mem_ready = 1'($urandom);
    @(negedge clk);
    check("idle", obs(), mkv(3, 0, 0, 0, 0, 0, 0, int'(exp_err)));
    for (int j = 1; j <= nd; j++) begin
      @(posedge clk); #1;
      i_op  = 2'($urandom);
      i_reg = 2'($urandom);
      if (j >= drop_at) begin
        i_req   = 1'b0;
        dropped = 1;
      end
      if (op < 2 && j >= 2) rdy = (j - 2 == d);
      else                  rdy = 1'($urandom);
      i_mem_ready = rdy;
      @(negedge clk);
      if (op >= 2)     e = mkv(rg, 1, int'(op == 3), 0, 0, 0, 0, 0);
      else if (j == 1) e = mkv(0, 1, 0, 1, 0, 0, 0, 0);
      else             e = mkv(1, 1, int'(op == 0 && rdy), 0, int'(op == 0), int'(op == 1), 0, 0);
      check($sformatf("busy op%0d c%0d", op, j), obs(), e);
    end
    exp_err = (op < 2) && (d >= W);
    h = dropped ? 0 : $urandom_range(0, 2);
    for (int i = 0; i <= h; i++) begin
      @(posedge clk); #1;
      i_req       = (i < h);
      i_mem_ready = 1'($urandom);
      i_op        = 2'($urandom);
      @(negedge clk);
      check($sformatf("done op%0d h%0d", op, i), obs(), mkv(3, 0, 0, 0, 0, 0, 1, int'(exp_err)));
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_err     = 1'b0;
    reset       = 1'b1;
    i_req       = 1'b0;
    i_op        = 2'd0;
    i_reg       = 2'd0;
    i_mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", obs(), mkv(3, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_hold", obs(), mkv(3, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("after_reset_idle", obs(), mkv(3, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    run_txn(0, 0, 0, 99);   // read, ready immediately
    run_txn(1, 0, 3, 99);   // write, three wait cycles
    run_txn(3, 2, 0, 99);   // register write
    run_txn(2, 1, 0, 99);   // register read, back to back
    run_txn(0, 0, 9, 99);   // read timeout
    run_txn(1, 0, W - 1, 99); // ready in final allowed cycle
    run_txn(0, 0, 1, 3);    // req dropped in DATA

    for (int t = 0; t < 150; t++) begin
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, W + 2)), int'($urandom_range(1, 9)));
    end

    // Timeout, then reset asserted during DATA of the next read.
    run_txn(0, 0, 9, 99);
    i_req       = 1'b1;
    i_op        = 2'd0;
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_idle", obs(), mkv(3, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_data", obs(), mkv(1, 1, 0, 0, 1, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check("rst_in_data", obs(), mkv(3, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_then_idle", obs(), mkv(3, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
